halt_ctrl: RTL

//  Parametrised halt controller for the fm2030 core; successor to the single PC==end comparator.

---
 rtl/halt_pkg.sv | 26 ++
 rtl/halt_ctrl_bp_match.sv | 54 +++++
 rtl/halt_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/halt_pkg.sv
// Shared types for the fm2030 halt controller.
// Cause encoding and FSM state for halt_ctrl and its breakpoint matcher.
package halt_pkg;

  localparam logic [2:0] CAUSE_NONE_C  = 3'd0;
  localparam logic [2:0] CAUSE_END_C   = 3'd1;
  localparam logic [2:0] CAUSE_BREAK_C = 3'd2;
  localparam logic [2:0] CAUSE_WDOG_C  = 3'd3;
  localparam logic [2:0] CAUSE_STEP_C  = 3'd4;

  typedef enum logic [2:0] {
    CAUSE_NONE  = CAUSE_NONE_C,
    CAUSE_END   = CAUSE_END_C,
    CAUSE_BREAK = CAUSE_BREAK_C,
    CAUSE_WDOG  = CAUSE_WDOG_C,
    CAUSE_STEP  = CAUSE_STEP_C
  } halt_cause_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SKIP,
    ST_HALT,
    ST_DONE
  } halt_state_t;

endpackage

// File: rtl/halt_ctrl_bp_match.sv
// Breakpoint register file with lowest-index-wins match encoder.
// Compares against the registered (pre-write) breakpoint values.
module bp_match
  import halt_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int NUM_BP   = 2,
  parameter int BP_IDX_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_idx,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_en,
  input  logic [PC_W-1:0]     pc_curr,
  output logic                hit,
  output logic [BP_IDX_W-1:0] idx
);

  logic [NUM_BP-1:0][PC_W-1:0] addr_q;
  logic [NUM_BP-1:0]           en_q;
  logic [NUM_BP-1:0]           match;

  // Out-of-range indices select no channel, so the write drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      en_q   <= '0;
    end else if (bp_we) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_idx == BP_IDX_W'(i)) begin
          addr_q[i] <= bp_addr;
          en_q[i]   <= bp_en;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = en_q[i] && (addr_q[i] == pc_curr);
    end
  end

  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (match[i]) idx = BP_IDX_W'(i);
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Halt controller: program end, breakpoints, watchdog, single-step.
// Holds the FSM, watchdog counter and retired-instruction counter.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 2,
  parameter int CYC_W  = 16,
  localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_W-1:0]     pc_curr,
  input  logic [PC_W-1:0]     pc_end,
  input  logic                pc_valid,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_idx,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_en,
  input  logic                step_mode,
  input  logic [CYC_W-1:0]    cyc_limit,
  input  logic                resume,
  output logic                halt,
  output logic [2:0]          halt_cause,
  output logic [BP_IDX_W-1:0] halt_bp_idx,
  output logic [CYC_W-1:0]    instr_count
);

  halt_state_t         state_q, state_d;
  halt_cause_t         cause_q, cause_d;
  logic                halt_q, halt_d;
  logic [BP_IDX_W-1:0] idx_q, idx_d;
  logic [CYC_W-1:0]    wdog_q, wdog_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d;
  logic [CYC_W-1:0]    wdog_inc;
  logic                bp_hit;
  logic [BP_IDX_W-1:0] bp_hit_idx;
  logic                end_hit;
  logic                wdog_hit;
  logic                active;

  bp_match #(
    .PC_W     (PC_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) u_bp (
    .clk     (clk),
    .reset   (reset),
    .bp_we   (bp_we),
    .bp_idx  (bp_idx),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .pc_curr (pc_curr),
    .hit     (bp_hit),
    .idx     (bp_hit_idx)
  );

  assign active   = (state_q == ST_RUN) || (state_q == ST_SKIP);
  assign end_hit  = pc_valid && (pc_curr == pc_end);
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + CYC_W'(1);
  // Fires on the edge at which the count reaches the limit.
  assign wdog_hit = (cyc_limit != '0) && (wdog_inc >= cyc_limit);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    halt_d  = halt_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    if (active) begin
      wdog_d = wdog_inc;
      if (pc_valid && (cnt_q != '1)) cnt_d = cnt_q + CYC_W'(1);
    end
    unique case (state_q)
      ST_RUN: begin
        if (end_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_END;
          halt_d  = 1'b1;
          idx_d   = '0;
        end else if (pc_valid && bp_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_BREAK;
          halt_d  = 1'b1;
          idx_d   = bp_hit_idx;
        end else if (wdog_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_WDOG;
          halt_d  = 1'b1;
          idx_d   = '0;
        end
      end
      ST_SKIP: begin
        if (end_hit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_END;
          halt_d  = 1'b1;
        end else if (pc_valid && step_mode) begin
          state_d = ST_HALT;
          cause_d = CAUSE_STEP;
          halt_d  = 1'b1;
        end else if (pc_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_SKIP;
          cause_d = CAUSE_NONE;
          halt_d  = 1'b0;
          idx_d   = '0;
          wdog_d  = '0;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      halt_q  <= 1'b0;
      idx_q   <= '0;
      wdog_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      halt_q  <= halt_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halt        = halt_q;
  assign halt_cause  = cause_q;
  assign halt_bp_idx = idx_q;
  assign instr_count = cnt_q;

endmodule
